addsub_seq: RTL
===============

Name: addsub_seq

Overview:
- Multi-precision add/subtract sequencer built around one shared N-bit adder/subtractor slice.
- The slice sits outside this block. This block drives the slice's x, y, ci and k inputs and samples its s and cu outputs.
- One word per cycle, LSW first, for WORDS words. Each word's carry out feeds the next word's carry in.
- Delivers an N*WORDS-bit result with carry-out and signed-overflow flags through a start/busy/done handshake.

Parameters:
- N, 4, slice width in bits.
- WORDS, 4, number of slice words per operand; operand width W = N*WORDS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = add, 1 = subtract; captured with start.
- cin  input  1  carry-in for add; captured with start; ignored for subtract.
- a  input  W  operand A; captured with start.
- b  input  W  operand B; captured with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  W  A+B+cin or A-B; held until the next accepted start.
- cout  output  1  final carry out; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow of the W-bit operation.
- au_x  output  N  word idx of captured A, to slice x.
- au_y  output  N  word idx of captured B, to slice y.
- au_ci  output  1  slice carry in.
- au_k  output  1  slice add/sub select, equal to captured op.
- au_s  input  N  slice sum; combinational from au_x, au_y, au_ci, au_k.
- au_cu  input  1  slice carry out.

Behaviour:
- Slice contract: s/cu = x + (y XOR {N{k}}) + ci, purely combinational, settles within one cycle.
- Reset: state IDLE; busy, done, cout and ovf = 0; result = 0; operand registers = 0; idx = 0; carry register = 0.
- In IDLE, au_x, au_y, au_ci and au_k are driven 0.
- IDLE: start=1 captures a, b and op; sets idx = 0; loads carry register with cin if op=0, or 1 if op=1. Next state RUN.
- RUN: au_x/au_y = word idx of A/B; au_ci = carry register; au_k = op.
- RUN, each edge: result word idx <= au_s; carry register <= au_cu; idx increments.
- RUN exit: on the edge where idx = WORDS-1 is captured, go to DONE; load cout <= au_cu; load ovf.
- ovf = (A[W-1] == Beff[W-1]) AND (au_s[N-1] != A[W-1]), where Beff = B XOR {W{op}}.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge E0 → words captured at E1..E(WORDS) → done high for the cycle after E(WORDS). That is WORDS+1 cycles from the start edge to done.
- busy rises the cycle after the start edge and falls together with done.
- Result-register behaviour:
  - result is updated word by word during RUN; it is only valid while done=1 and afterwards in IDLE.
  - result, cout and ovf are held in IDLE until the next accepted start.
  - cout and ovf keep their previous values during RUN.
- start while busy=1 is ignored: no capture, no effect on the operation in progress.
- start asserted in the same cycle done is high is ignored; it is accepted in the following IDLE cycle if still high.
- rst during RUN or DONE aborts immediately: reset values apply at that edge, no done pulse.
- WORDS=1 is legal: a single RUN cycle.
- Back-to-back operations: minimum start-to-start spacing is WORDS+2 cycles.

Test Plan:
- Use N=4, WORDS=4 (W=16) for all scenarios.
- Add, op=0, cin=0, a=0x0001, b=0x0001 → au_ci sequence 0,0,0,0; result=0x0002, cout=0, ovf=0; done exactly 5 cycles after the start edge; busy high 5 cycles.
- Full ripple add, op=0, cin=0, a=0xFFFF, b=0x0001 → au_ci sequence 0,1,1,1; result=0x0000, cout=1, ovf=0.
- Add with cin=1, a=0x7FFE, b=0x0001 → result=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000, cin=0 → result=0x0000, cout=1, ovf=1.
- Subtract, op=1:
  - a=0x0005, b=0x0003 → first au_ci=1, au_k=1 for all 4 words; result=0x0002, cout=1, ovf=0.
  - a=0x0000, b=0x0001 → result=0xFFFF, cout=0, ovf=0.
  - a=0x8000, b=0x0001 → result=0x7FFF, ovf=1.
- Handshake robustness:
  - start pulsed again 2 cycles into RUN with different operands → ignored; first result unchanged.
  - Hold start high continuously → operations accepted every 6 cycles.
- Reset mid-operation: rst=1 at the 2nd RUN cycle → next cycle busy=0, done=0, result=0x0000, cout=0, ovf=0; no done pulse. A following add 0x1234+0x1111 returns 0x2345.

Source files
------------

// File: rtl/addsub_seq.sv
// Multi-precision add/subtract sequencer: walks WORDS slices of N bits through an
// external adder/subtractor slice, LSW first, rippling the carry between words.
module addsub_seq #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op,
    input  logic               cin,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] result,
    output logic               cout,
    output logic               ovf,
    output logic [N-1:0]       au_x,
    output logic [N-1:0]       au_y,
    output logic               au_ci,
    output logic               au_k,
    input  logic [N-1:0]       au_s,
    input  logic               au_cu
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [WORDS-1:0][N-1:0]   r_a;
    logic [WORDS-1:0][N-1:0]   r_b;
    logic [WORDS-1:0][N-1:0]   r_res;
    logic                      r_op;
    logic                      r_carry;
    logic [IW-1:0]             r_idx;
    logic                      r_cout;
    logic                      r_ovf;
    logic                      w_last;
    logic                      w_ovf;

    assign w_last = (r_idx == IW'(WORDS - 1));

    // Sign of the top word of A against the effective (possibly inverted) B sign.
    assign w_ovf = (r_a[WORDS-1][N-1] == (r_b[WORDS-1][N-1] ^ r_op)) &&
                   (au_s[N-1] != r_a[WORDS-1][N-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        au_x  = '0;
        au_y  = '0;
        au_ci = 1'b0;
        au_k  = 1'b0;
        case (r_state)
            S_RUN: begin
                busy  = 1'b1;
                au_x  = r_a[r_idx];
                au_y  = r_b[r_idx];
                au_ci = r_carry;
                au_k  = r_op;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_op    <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_idx   <= '0;
                        // Subtract is A + ~B + 1, so the initial carry is forced to 1.
                        r_carry <= op | cin;
                    end
                end
                S_RUN: begin
                    r_res[r_idx] <= au_s;
                    r_carry      <= au_cu;
                    r_idx        <= r_idx + IW'(1);
                    if (w_last) begin
                        r_cout <= au_cu;
                        r_ovf  <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_res;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule
